// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: register map offsets and FSM states.
package irq_pkg;

  localparam int MAX_SRC = 8;

  localparam logic [7:0] OFS_PEND = 8'd0;
  localparam logic [7:0] OFS_MASK = 8'd1;
  localparam logic [7:0] OFS_ID   = 8'd2;
  localparam logic [7:0] OFS_CLR  = 8'd3;
  localparam logic [7:0] OFS_DROP = 8'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set request bit searching upward from ptr, wrapping at NumSrc.
module rr_select
  import irq_pkg::*;
#(
  parameter int NumSrc = 4
) (
  input  logic [MAX_SRC-1:0] req,
  input  logic [2:0]         ptr,
  output logic               valid,
  output logic [2:0]         index
);

  logic [2:0] cand;

  // Walk NumSrc candidates; the wrap compares against NumSrc-1 so non power-of-2 counts work.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = ptr;
    for (int i = 0; i < NumSrc; i++) begin
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
      cand = (cand == 3'(NumSrc - 1)) ? 3'd0 : cand + 3'd1;
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Bus-mapped interrupt controller: latches source edges as pending, masks them and
// presents one source at a time to the CPU in round-robin order.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter logic [7:0] BaseAddr    = 8'hE8,
  parameter int         NumSrc      = 4,
  parameter logic [7:0] InitialMask = 8'hFF
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [7:0]        BUS_DATA,
  input  logic [7:0]        BUS_ADDR,
  input  logic              BUS_WE,
  input  logic [NumSrc-1:0] SRC_IRQ_RAISE,
  output logic [NumSrc-1:0] SRC_IRQ_ACK,
  output logic              CPU_IRQ_RAISE,
  input  logic              CPU_IRQ_ACK
);

  logic [7:0]         ofs;
  logic               in_window, rd_hit;
  logic               wr_mask, wr_clr, wr_drop;
  logic               rd_en;
  logic [7:0]         rd_ofs;
  logic [7:0]         rdata;

  logic [NumSrc-1:0]  raise_q;
  logic [NumSrc-1:0]  rise;
  logic [NumSrc-1:0]  pending;
  logic [NumSrc-1:0]  pending_nxt;
  logic [NumSrc-1:0]  ack_clr;
  logic [NumSrc-1:0]  w1c_clr;
  logic [NumSrc-1:0]  id_onehot;
  logic               drop_hit;
  logic [7:0]         mask;
  logic [7:0]         drop_cnt;

  state_t             state;
  logic [2:0]         rr_ptr;
  logic [2:0]         cur_id;
  logic [2:0]         rr_next;
  logic [MAX_SRC-1:0] req;
  logic               sel_valid;
  logic [2:0]         sel_idx;

  assign ofs       = BUS_ADDR - BaseAddr;
  assign in_window = (ofs <= OFS_DROP);
  // Reads are only decoded with BUS_WE low so the driver never fights a bus master's write.
  assign rd_hit    = !BUS_WE && in_window && (ofs != OFS_CLR);
  assign wr_mask   = BUS_WE && (ofs == OFS_MASK);
  assign wr_clr    = BUS_WE && (ofs == OFS_CLR);
  assign wr_drop   = BUS_WE && (ofs == OFS_DROP);

  assign rise      = SRC_IRQ_RAISE & ~raise_q;
  assign id_onehot = NumSrc'(1) << cur_id;
  assign ack_clr   = (state == RAISE && CPU_IRQ_ACK) ? id_onehot : '0;
  assign w1c_clr   = wr_clr ? BUS_DATA[NumSrc-1:0] : '0;
  // New edges override both clear paths so a re-raise in the same cycle is never lost.
  assign pending_nxt = (pending & ~ack_clr & ~w1c_clr) | rise;
  assign drop_hit    = |(rise & pending);

  assign req     = MAX_SRC'(pending & mask[NumSrc-1:0]);
  assign rr_next = (cur_id == 3'(NumSrc - 1)) ? 3'd0 : cur_id + 3'd1;

  rr_select #(.NumSrc(NumSrc)) u_rr_select (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (sel_valid),
    .index (sel_idx)
  );

  always_comb begin
    rdata = '0;
    case (rd_ofs)
      OFS_PEND: rdata = 8'(pending);
      OFS_MASK: rdata = mask;
      OFS_ID:   rdata = {5'd0, cur_id};
      OFS_DROP: rdata = drop_cnt;
      default:  rdata = '0;
    endcase
  end

  assign BUS_DATA = rd_en ? rdata : 8'hZZ;

  // Capture, register file and read-enable stage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      raise_q     <= '0;
      SRC_IRQ_ACK <= '0;
      pending     <= '0;
      mask        <= InitialMask;
      drop_cnt    <= '0;
      rd_en       <= 1'b0;
      rd_ofs      <= '0;
    end else begin
      raise_q     <= SRC_IRQ_RAISE;
      SRC_IRQ_ACK <= rise;
      pending     <= pending_nxt;
      rd_en       <= rd_hit;
      rd_ofs      <= ofs;
      if (wr_mask) mask <= BUS_DATA;
      if (wr_drop) drop_cnt <= '0;
      else if (drop_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Arbitration FSM
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      cur_id        <= '0;
      rr_ptr        <= '0;
      CPU_IRQ_RAISE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            cur_id        <= sel_idx;
            CPU_IRQ_RAISE <= 1'b1;
            state         <= RAISE;
          end
        end
        RAISE: begin
          if (CPU_IRQ_ACK) begin
            rr_ptr        <= rr_next;
            CPU_IRQ_RAISE <= 1'b0;
            state         <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: per-cycle vector table plus hand sequences for multi-cycle cases.
module tb_irq_arbiter;

  localparam logic [7:0] BASE = 8'hE8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       we;
  logic [3:0] src;
  logic [3:0] sack;
  logic       cpu_raise;
  logic       cpu_ack;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  int checks = 0;
  int errors = 0;

  assign bus_data = tb_drv ? tb_wdata : 8'hZZ;

  irq_arbiter #(.BaseAddr(BASE), .NumSrc(4), .InitialMask(8'hFF)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .BUS_DATA      (bus_data),
    .BUS_ADDR      (addr),
    .BUS_WE        (we),
    .SRC_IRQ_RAISE (src),
    .SRC_IRQ_ACK   (sack),
    .CPU_IRQ_RAISE (cpu_raise),
    .CPU_IRQ_ACK   (cpu_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [3:0] src;
    logic       ack;
    logic [7:0] addr;
    logic       exp_raise;
    logic [3:0] exp_sack;
    logic       chk_d;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[$];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; cpu_ack = 1'b0; addr = 8'h00; we = 1'b0; tb_drv = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] o, input logic [7:0] d);
    addr = BASE + o; we = 1'b1; tb_drv = 1'b1; tb_wdata = d;
    cyc();
    we = 1'b0; tb_drv = 1'b0; addr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] o, output logic [7:0] d);
    addr = BASE + o; we = 1'b0;
    cyc();
    d = bus_data;
    addr = 8'h00;
  endtask

  task automatic wait_raise(input string name);
    int n = 0;
    while (!cpu_raise && n < 20) begin
      cyc();
      n++;
    end
    check(name, {7'd0, cpu_raise}, 8'h01);
  endtask

  task automatic ack_pulse();
    cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] d;

    // single source 0, then 0/2/3 round-robin with wrap
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 8'hEA, 1'b1, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 8'hE8, 1'b1, 4'b0000, 1'b1, 8'h01});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 8'hE8, 1'b0, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 4'b1101, 1'b0, 8'h00, 1'b0, 4'b1101, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b1101, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b1101, 1'b0, 8'hEA, 1'b1, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 4'b1101, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b1101, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b1101, 1'b0, 8'hEA, 1'b1, 4'b0000, 1'b1, 8'h02});
    tbl.push_back('{1'b0, 4'b1101, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b1101, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b1101, 1'b0, 8'hEA, 1'b1, 4'b0000, 1'b1, 8'h03});
    tbl.push_back('{1'b0, 4'b1101, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0100, 1'b1, 8'h00, 1'b0, 4'b0100, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0101, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0101, 1'b0, 8'hEA, 1'b1, 4'b0000, 1'b1, 8'h02});
    tbl.push_back('{1'b0, 4'b0101, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0101, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0101, 1'b0, 8'hEA, 1'b1, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 4'b0101, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0101, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 4'b0101, 1'b0, 8'hE8, 1'b0, 4'b0000, 1'b1, 8'h00});

    rst = 1'b1; src = '0; cpu_ack = 1'b0; addr = 8'h00; we = 1'b0;
    tb_drv = 1'b0; tb_wdata = 8'h00;
    cyc(); cyc();
    check("rst_raise", {7'd0, cpu_raise}, 8'h00);
    check("rst_sack", {4'd0, sack}, 8'h00);
    rst = 1'b0;
    bus_read(8'd0, d); check("rst_pend", d, 8'h00);
    bus_read(8'd1, d); check("rst_mask", d, 8'hFF);
    bus_read(8'd2, d); check("rst_id", d, 8'h00);
    bus_read(8'd4, d); check("rst_drop", d, 8'h00);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      src = tbl[i].src; cpu_ack = tbl[i].ack; addr = tbl[i].addr; we = 1'b0;
      cyc();
      check($sformatf("vec%0d_raise", i), {7'd0, cpu_raise}, {7'd0, tbl[i].exp_raise});
      check($sformatf("vec%0d_sack", i), {4'd0, sack}, {4'd0, tbl[i].exp_sack});
      if (tbl[i].chk_d) check($sformatf("vec%0d_data", i), bus_data, tbl[i].exp_d);
    end
    cpu_ack = 1'b0; addr = 8'h00;

    // masking holds source 0 pending until unmasked
    do_reset();
    bus_write(8'd1, 8'h02);
    src = 4'b0011;
    cyc(); check("mask_sack", {4'd0, sack}, 8'h03);
    cyc(); check("mask_raise", {7'd0, cpu_raise}, 8'h01);
    bus_read(8'd2, d); check("mask_id", d, 8'h01);
    bus_read(8'd0, d); check("mask_pend", d, 8'h03);
    ack_pulse();
    check("mask_ack_low", {7'd0, cpu_raise}, 8'h00);
    src = 4'b0000;
    cyc(); cyc(); cyc();
    check("mask_held_low", {7'd0, cpu_raise}, 8'h00);
    bus_write(8'd1, 8'hFF);
    wait_raise("unmask_raise");
    bus_read(8'd2, d); check("unmask_id", d, 8'h00);
    ack_pulse();
    cyc(); cyc();
    bus_read(8'd0, d); check("unmask_pend", d, 8'h00);

    // drop counter and saturation
    do_reset();
    for (int k = 0; k < 3; k++) begin
      src = 4'b1000; cyc(); src = 4'b0000; cyc();
    end
    bus_read(8'd4, d); check("drop_2", d, 8'h02);
    for (int k = 0; k < 300; k++) begin
      src = 4'b1000; cyc(); src = 4'b0000; cyc();
    end
    bus_read(8'd4, d); check("drop_sat", d, 8'hFF);
    bus_write(8'd4, 8'h00);
    bus_read(8'd4, d); check("drop_clr", d, 8'h00);

    // same-cycle conflicts on bit 2
    do_reset();
    src = 4'b0100; addr = BASE + 8'd3; we = 1'b1; tb_drv = 1'b1; tb_wdata = 8'h04;
    cyc();
    we = 1'b0; tb_drv = 1'b0; addr = 8'h00; src = 4'b0000;
    bus_read(8'd0, d); check("set_w1c_pend", d, 8'h04);
    wait_raise("set_w1c_raise");
    bus_read(8'd2, d); check("set_w1c_id", d, 8'h02);
    cpu_ack = 1'b1; src = 4'b0100;
    cyc();
    cpu_ack = 1'b0;
    check("set_ack_gap", {7'd0, cpu_raise}, 8'h00);
    bus_read(8'd0, d); check("set_ack_pend", d, 8'h04);
    wait_raise("set_ack_reraise");
    bus_read(8'd2, d); check("set_ack_id", d, 8'h02);
    ack_pulse();
    src = 4'b0000;

    // asynchronous reset while raised
    do_reset();
    bus_write(8'd1, 8'h02);
    src = 4'b0010;
    cyc(); cyc();
    check("pre_rst_raise", {7'd0, cpu_raise}, 8'h01);
    #2 rst = 1'b1; src = 4'b0000;
    #1 check("async_rst_raise", {7'd0, cpu_raise}, 8'h00);
    cyc();
    rst = 1'b0;
    bus_read(8'd0, d); check("post_rst_pend", d, 8'h00);
    bus_read(8'd1, d); check("post_rst_mask", d, 8'hFF);
    cyc(); cyc();
    check("post_rst_raise", {7'd0, cpu_raise}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Bus-mapped interrupt controller between up to 8 peripheral interrupt sources (timer, mouse, IR, …) and the single CPU interrupt raise/ack pair.
- Latches source events as pending and applies a mask.
- Round-robin arbitration presents one source at a time to the CPU, with its ID readable on the 8-bit data bus.
- Returns an ack pulse to each source so source-held raise lines drop.

Parameters:
- BaseAddr, 8'hE8, base address of the 5-register window (BaseAddr+0 … +4).
- NumSrc, 4, number of sources (1–8).
- InitialMask, 8'hFF, mask value after reset; bit i enables source i.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RESET  input  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; tristated when not reading.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write enable.
- SRC_IRQ_RAISE  input  NumSrc  per-source raise; level held until acked.
- SRC_IRQ_ACK  output  NumSrc  per-source one-cycle ack pulse.
- CPU_IRQ_RAISE  output  1  interrupt request to CPU.
- CPU_IRQ_ACK  input  1  CPU acknowledge.

Behaviour:
- Reset (async): all state cleared, regardless of FSM state.
  - pending=0, drop_cnt=0, mask=InitialMask, rr_ptr=0, cur_id=0, state=IDLE.
  - CPU_IRQ_RAISE=0, SRC_IRQ_ACK=0, bus driver off.
- Capture, per source i:
  - Registered copy of SRC_IRQ_RAISE gives rising-edge detect.
  - On edge: pending[i]<=1 and SRC_IRQ_ACK[i]=1 for exactly the next cycle.
  - Edge while pending[i] already 1: drop_cnt+1, saturating at 255; pending stays 1.
- Registers:
  - +0, R: pending[NumSrc-1:0]; upper bits 0.
  - +1, R/W: mask.
  - +2, R: cur_id, zero-extended.
  - +3, W1C: clears pending bits written as 1.
  - +4, R: drop_cnt; any write clears it.
  - Writes take effect on the clock edge where BUS_WE=1 and the address matches.
- Read timing:
  - Drive-enable registered from address decode; one-cycle latency.
  - BUS_DATA driven in the cycle after BUS_ADDR matches a readable offset, with current register contents.
  - BUS_DATA=8'hZZ otherwise, and never driven for +3.
- FSM, 3 states:
  - IDLE: if (pending & mask)!=0, select the first set bit searching upward from rr_ptr with wrap at NumSrc; cur_id<=sel; ->RAISE. CPU_IRQ_RAISE is registered high on entry, 1 cycle after the pending bit is visible.
  - RAISE: hold CPU_IRQ_RAISE=1. On CPU_IRQ_ACK: pending[cur_id]<=0, rr_ptr<=(cur_id+1) mod NumSrc, CPU_IRQ_RAISE<=0, ->GAP.
  - GAP: one cycle with CPU_IRQ_RAISE=0, then ->IDLE. Guarantees a visible low between back-to-back interrupts.
- Pending updates, same-cycle conflicts (all apply to the same bit):
  - Set and ack-clear together: set wins; the source re-interrupts later.
  - Set and W1C together: set wins.
  - Ack-clear and W1C together: result 0.
- Mask cleared for cur_id while in RAISE: request not retracted; completes on ack.
- W1C of cur_id during RAISE: raise held until ack; clearing an already-0 bit is harmless.
- CPU_IRQ_ACK in IDLE/GAP: ignored.
- Masked pending bits remain pending and are arbitrated once unmasked.
- Arithmetic: rr_ptr and cur_id are 3 bits; wrap uses compare against NumSrc-1, not a power-of-2 assumption.

Decomposition:
- Shared package irq_pkg:
  - Register offsets: OFS_PEND=0, OFS_MASK=1, OFS_ID=2, OFS_CLR=3, OFS_DROP=4.
  - FSM state encoding: IDLE, RAISE, GAP.
  - MAX_SRC=8.
- One sub-module: rr_select, purely combinational. Inputs: request vector, rr_ptr. Outputs: valid, index.

Test Plan:
- Reset mid-RAISE with source 1 pending -> CPU_IRQ_RAISE=0 immediately (async), pending=0, mask=8'hFF, read of +0 returns 8'h00.
- Source 0 rises at t0 -> SRC_IRQ_ACK[0] high one cycle at t0+1; CPU_IRQ_RAISE high at t0+2; read +2 returns 8'h00; CPU ack -> raise low next cycle, pending=0, GAP one cycle.
- Sources 0,2,3 rise together, rr_ptr=0 -> grants in order 0,2,3; then source 0 again with rr_ptr=1 and source 2 pending -> grant 2 before 0 (round-robin wrap).
- Write mask=8'h02, sources 0 and 1 rise -> only 1 raised; read +0 returns 8'h03; write mask=8'hFF -> source 0 raised after GAP.
- Source 3 edge twice without service, then third edge -> drop_cnt reads 8'h02; 300 extra edges -> 8'hFF; write +4 -> 8'h00.
- Same-cycle source-2 edge and W1C of bit 2 -> pending[2]=1; same-cycle CPU ack of 2 and new source-2 edge -> pending[2]=1, re-raised after GAP.
